// File: rtl/user_pkg.sv
// Shared constants and types for the audio I2S receiver slice.
// Stereo pairs are stored as a packed {left, right} struct.
package user_pkg;

   localparam int AuSampleWidth  = 16;
   localparam int AuI2sFifoDepth = 4;

   typedef struct packed {
      logic [AuSampleWidth-1:0] left;
      logic [AuSampleWidth-1:0] right;
   } au_stereo_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SHIFT
   } au_rx_state_e;

endpackage

// File: rtl/au_i2s_rx_fifo.sv
// Stereo-pair FIFO with head-of-queue read, flush, and full/empty flags.
// Pointers carry one extra MSB so full and empty are distinguishable.
module au_i2s_rx_fifo
   import user_pkg::*;
#(
   parameter int Depth = AuI2sFifoDepth
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  au_stereo_t wdata,
   output au_stereo_t rdata,
   output logic       full,
   output logic       empty
);

   localparam int AddrW = $clog2(Depth);

   logic [AddrW:0] wptr;
   logic [AddrW:0] rptr;
   au_stereo_t     mem [Depth];
   logic           do_push;
   logic           do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AddrW] != rptr[AddrW]) && (wptr[AddrW-1:0] == rptr[AddrW-1:0]);
   assign do_pop  = pop && !empty;
   // When full, a same-cycle pop frees the head slot, which is the one being written.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rptr[AddrW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
         mem  <= '{default: '0};
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) begin
            mem[wptr[AddrW-1:0]] <= wdata;
            wptr                 <= wptr + (AddrW+1)'(1);
         end
         if (do_pop) begin
            rptr <= rptr + (AddrW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/au_i2s_rx.sv
// Stereo I2S receiver: oversampled on clk_i, deserializes left/right words, buffers pairs.
// Define AU_I2S_RX_DROP_CNT_EN to build the saturating dropped-pair counter on drop_cnt_o.
module au_i2s_rx
   import user_pkg::*;
#(
   parameter int SampleWidth = AuSampleWidth,
   parameter int FifoDepth   = AuI2sFifoDepth
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   enable_i,
   input  logic                   clear_ovf_i,
   input  logic                   i2s_sck_i,
   input  logic                   i2s_ws_i,
   input  logic                   i2s_sd_i,
   output logic                   sample_valid_o,
   input  logic                   sample_ready_i,
   output logic [SampleWidth-1:0] sample_left_o,
   output logic [SampleWidth-1:0] sample_right_o,
   output logic                   overflow_o,
   output logic [15:0]            drop_cnt_o
);

   // state    | meaning
   // ST_IDLE  | disabled; deserializer and FIFO held clear
   // ST_SYNC  | waiting for a WS falling edge (left-channel start)
   // ST_SHIFT | deserializing words and pushing completed pairs

   localparam int CntW = $clog2(SampleWidth + 1);

   logic [1:0]             sck_sync;
   logic [1:0]             ws_sync;
   logic [1:0]             sd_sync;
   logic                   sck_prev;
   logic                   sck_rise;
   logic                   ws_q;
   logic                   sd_q;
   logic                   ws_prev;
   au_rx_state_e           state;
   au_rx_state_e           state_nxt;
   logic [SampleWidth-1:0] shift_reg;
   logic [SampleWidth-1:0] shift_nxt;
   logic [SampleWidth-1:0] left_word;
   logic [CntW-1:0]        bitcnt;
   logic                   ch;
   logic                   flush;
   logic                   bit_en;
   logic                   word_end;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   overflow;
   au_stereo_t             push_data;
   au_stereo_t             head;

   // WS and SD are delayed alongside the registered rise strobe so all three stay aligned.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_sync <= '0;
         ws_sync  <= '0;
         sd_sync  <= '0;
         sck_prev <= 1'b0;
         sck_rise <= 1'b0;
         ws_q     <= 1'b0;
         sd_q     <= 1'b0;
         ws_prev  <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[0], i2s_sck_i};
         ws_sync  <= {ws_sync[0], i2s_ws_i};
         sd_sync  <= {sd_sync[0], i2s_sd_i};
         sck_prev <= sck_sync[1];
         sck_rise <= sck_sync[1] & ~sck_prev;
         ws_q     <= ws_sync[1];
         sd_q     <= sd_sync[1];
         if (sck_rise) begin
            ws_prev <= ws_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      bit_en    = 1'b0;
      word_end  = 1'b0;
      case (state)
         ST_IDLE: begin
            flush = 1'b1;
            if (enable_i) state_nxt = ST_SYNC;
         end
         ST_SYNC: begin
            if (!enable_i) state_nxt = ST_IDLE;
            else if (sck_rise && !ws_q && ws_prev) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (!enable_i) begin
               state_nxt = ST_IDLE;
            end else if (sck_rise) begin
               bit_en   = (bitcnt < CntW'(SampleWidth));
               word_end = (ws_q != ws_prev);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The shift register is cleared per word, so each bit is ORed in exactly once.
   assign shift_nxt = bit_en ? (shift_reg | (SampleWidth'(sd_q) << (CntW'(SampleWidth - 1) - bitcnt)))
                             : shift_reg;
   assign push      = word_end && ch;
   assign push_data = '{left: left_word, right: shift_nxt};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_reg <= '0;
         bitcnt    <= '0;
         ch        <= 1'b0;
         left_word <= '0;
      end else if (state != ST_SHIFT) begin
         shift_reg <= '0;
         bitcnt    <= '0;
         ch        <= 1'b0;
         if (state == ST_IDLE) left_word <= '0;
      end else if (sck_rise && enable_i) begin
         if (word_end) begin
            if (!ch) left_word <= shift_nxt;
            shift_reg <= '0;
            bitcnt    <= '0;
            ch        <= ws_q;
         end else begin
            shift_reg <= shift_nxt;
            if (bit_en) bitcnt <= bitcnt + CntW'(1);
         end
      end
   end

   au_i2s_rx_fifo #(
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush  (flush),
      .push   (push),
      .pop    (pop),
      .wdata  (push_data),
      .rdata  (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign pop  = !fifo_empty && sample_ready_i;
   assign drop = push && fifo_full && !pop;

   // A drop in the same cycle as a clear wins, so the event is never lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clear_ovf_i) begin
         overflow <= 1'b0;
      end
   end

`ifdef AU_I2S_RX_DROP_CNT_EN
   logic [15:0] drop_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt <= '0;
      end else if (drop) begin
         if (clear_ovf_i) drop_cnt <= 16'd1;
         else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (clear_ovf_i) begin
         drop_cnt <= '0;
      end
   end

   assign drop_cnt_o = drop_cnt;
`else
   assign drop_cnt_o = '0;
`endif

   assign sample_valid_o = !fifo_empty;
   assign sample_left_o  = head.left;
   assign sample_right_o = head.right;
   assign overflow_o     = overflow;

endmodule
